// File: rtl/fetch_addr_sequencer_pkg.sv
// Shared CPU constants and types for the fetch/address path.
// Bus widths, FSM states and the registered bus bundle.
package fetch_addr_sequencer_pkg;

  localparam int ADDR_W        = 13;
  localparam int DATA_W        = 8;
  localparam int OPC_W         = 3;
  localparam int ROM_SPACE_MSB = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_HI = 2'd1,
    FETCH_LO = 2'd2,
    OPER     = 2'd3
  } fas_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
  } bus_t;

endpackage

// File: rtl/fetch_addr_sequencer_pc_counter.sv
// 12-bit wrapping program counter, kept inside ROM space.
// Load beats inc2, which beats inc1.
module pc_counter
  import fetch_addr_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [ROM_SPACE_MSB-1:0] load_val,
  input  logic                     inc1,
  input  logic                     inc2,
  output logic [ADDR_W-1:0]        pc_nxt,
  output logic [ADDR_W-1:0]        pc
);

  localparam int CW = ROM_SPACE_MSB;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count with natural 12-bit wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc2) begin
      cnt_d = cnt_q + CW'(2);
    end else if (inc1) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= PC_RESET[CW-1:0];
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pc     = {1'b0, cnt_q};
  assign pc_nxt = {1'b0, cnt_d};

endmodule

// File: rtl/fetch_addr_sequencer.sv
// Fetch/operand address sequencer: PC, two-byte fetch,
// operand access strobes and controller handshakes.
module fetch_addr_sequencer
  import fetch_addr_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET = 13'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              oper_req,
  input  logic              oper_wr,
  input  logic              jump,
  input  logic              skip,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              rd,
  output logic              wr,
  output logic              busy,
  output logic              ir_valid,
  output logic              done,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc
);

  localparam int HI_W = ADDR_W - DATA_W;

  fas_state_e state_q;
  fas_state_e state_d;
  bus_t       bus_q;
  bus_t       bus_d;

  logic [OPC_W-1:0]  opcode_q;
  logic [ADDR_W-1:0] ir_addr_q;
  logic [ADDR_W-1:0] pc_nxt;
  logic              oper_wr_q;
  logic              opw_d;
  logic              ir_valid_q;
  logic              done_q;

  logic pc_load;
  logic pc_inc1;
  logic pc_inc2;
  logic hi_we;
  logic lo_we;
  logic opw_we;
  logic is_fetch;
  logic is_oper;

  pc_counter #(
    .PC_RESET (PC_RESET)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (ir_addr_q[ROM_SPACE_MSB-1:0]),
    .inc1     (pc_inc1),
    .inc2     (pc_inc2),
    .pc_nxt   (pc_nxt),
    .pc       (pc)
  );

  // Next state, PC control and IR write enables.
  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_inc1 = 1'b0;
    pc_inc2 = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    opw_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_load = jump;
        pc_inc2 = skip & ~jump;
        if (oper_req) begin
          state_d = OPER;
          opw_we  = 1'b1;
        end else if (fetch_req) begin
          state_d = FETCH_HI;
        end
      end
      FETCH_HI: begin
        if (mem_valid) begin
          hi_we   = 1'b1;
          pc_inc1 = 1'b1;
          state_d = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (mem_valid) begin
          lo_we   = 1'b1;
          pc_inc1 = 1'b1;
          state_d = IDLE;
        end
      end
      OPER: begin
        if (mem_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus value for the cycle after this edge.
  always_comb begin
    is_fetch = (state_d == FETCH_HI) || (state_d == FETCH_LO);
    is_oper  = (state_d == OPER);
    opw_d    = opw_we ? oper_wr : oper_wr_q;
    bus_d    = '{addr: pc_nxt, rd: 1'b0, wr: 1'b0};
    unique case (1'b1)
      is_fetch: bus_d.rd = 1'b1;
      is_oper: begin
        bus_d.addr = ir_addr_q;
        bus_d.rd   = ~opw_d;
        bus_d.wr   = opw_d;
      end
      default: ;
    endcase
  end

  // FSM state, bus and handshake pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bus_q      <= '{addr: PC_RESET, rd: 1'b0, wr: 1'b0};
      ir_valid_q <= 1'b0;
      done_q     <= 1'b0;
      oper_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bus_q      <= bus_d;
      ir_valid_q <= lo_we;
      done_q     <= (state_q == OPER) & mem_valid;
      if (opw_we) begin
        oper_wr_q <= oper_wr;
      end
    end
  end

  // Instruction register, written a byte at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      ir_addr_q <= '0;
    end else begin
      if (hi_we) begin
        opcode_q <= data_in[DATA_W-1 -: OPC_W];
        ir_addr_q[ADDR_W-1:DATA_W] <= data_in[HI_W-1:0];
      end
      if (lo_we) begin
        ir_addr_q[DATA_W-1:0] <= data_in;
      end
    end
  end

  assign addr     = bus_q.addr;
  assign rd       = bus_q.rd;
  assign wr       = bus_q.wr;
  assign busy     = (state_q != IDLE);
  assign ir_valid = ir_valid_q;
  assign done     = done_q;
  assign opcode   = opcode_q;
  assign ir_addr  = ir_addr_q;

endmodule

// File: tb/tb_fetch_addr_sequencer.sv
// Randomized bench for fetch_addr_sequencer with a
// transaction-level model of PC, IR and bus behaviour.
module tb_fetch_addr_sequencer;

  localparam logic [12:0] PC_RST = 13'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic        oper_req;
  logic        oper_wr;
  logic        jump;
  logic        skip;
  logic [7:0]  data_in;
  logic        mem_valid;
  logic [12:0] addr;
  logic        rd;
  logic        wr;
  logic        busy;
  logic        ir_valid;
  logic        done;
  logic [2:0]  opcode;
  logic [12:0] ir_addr;
  logic [12:0] pc;

  int checks   = 0;
  int failures = 0;

  logic [12:0] exp_pc;
  logic [12:0] exp_ir;
  logic [2:0]  exp_opc;

  fetch_addr_sequencer #(
    .PC_RESET (PC_RST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_req (fetch_req),
    .oper_req  (oper_req),
    .oper_wr   (oper_wr),
    .jump      (jump),
    .skip      (skip),
    .data_in   (data_in),
    .mem_valid (mem_valid),
    .addr      (addr),
    .rd        (rd),
    .wr        (wr),
    .busy      (busy),
    .ir_valid  (ir_valid),
    .done      (done),
    .opcode    (opcode),
    .ir_addr   (ir_addr),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] adv(input logic [12:0] p,
                                      input int n);
    return 13'((int'(p) + n) % 4096);
  endfunction

  function automatic logic [12:0] jmp(input logic [12:0] a);
    return 13'(int'(a) % 4096);
  endfunction

  // Inputs that must be ignored while busy.
  task automatic noise();
    fetch_req = 1'($urandom);
    oper_req  = 1'($urandom);
    oper_wr   = 1'($urandom);
    jump      = 1'($urandom);
    skip      = 1'($urandom);
    data_in   = 8'($urandom);
  endtask

  task automatic quiet();
    fetch_req = 1'b0;
    oper_req  = 1'b0;
    jump      = 1'b0;
    skip      = 1'b0;
    mem_valid = 1'($urandom);
  endtask

  task automatic pre_idle(input logic j, input logic s);
    jump = j;
    skip = s;
    if (j) exp_pc = jmp(exp_ir);
    else if (s) exp_pc = adv(exp_pc, 2);
  endtask

  task automatic do_fetch(input int waits,
                          input logic [7:0] hi,
                          input logic [7:0] lo,
                          input logic j,
                          input logic s);
    quiet();
    fetch_req = 1'b1;
    pre_idle(j, s);
    tick();
    chk("f_hi_rd", rd, 1);
    chk("f_hi_addr", addr, exp_pc);
    chk("f_busy", busy, 1);
    chk("f_done0", done, 0);
    for (int w = 0; w < waits; w++) begin
      noise();
      mem_valid = 1'b0;
      tick();
      chk("f_hi_hold", {rd, wr, addr}, {2'b10, exp_pc});
      chk("f_irv0", ir_valid, 0);
    end
    noise();
    data_in   = hi;
    mem_valid = 1'b1;
    tick();
    exp_pc  = adv(exp_pc, 1);
    exp_opc = hi[7:5];
    exp_ir  = {hi[4:0], exp_ir[7:0]};
    chk("f_lo_bus", {rd, wr, addr}, {2'b10, exp_pc});
    chk("f_opc", opcode, exp_opc);
    for (int w = 0; w < waits; w++) begin
      noise();
      mem_valid = 1'b0;
      tick();
      chk("f_lo_hold", {rd, wr, addr}, {2'b10, exp_pc});
      chk("f_irv0", ir_valid, 0);
    end
    noise();
    data_in   = lo;
    mem_valid = 1'b1;
    tick();
    quiet();
    exp_pc = adv(exp_pc, 1);
    exp_ir = {exp_ir[12:8], lo};
    chk("f_irv", ir_valid, 1);
    chk("f_ir", {opcode, ir_addr}, {exp_opc, exp_ir});
    chk("f_pc", pc, exp_pc);
    chk("f_idle", {busy, rd, wr, addr}, {3'b000, exp_pc});
  endtask

  task automatic do_oper(input logic w,
                         input int waits,
                         input logic also_fetch,
                         input logic j,
                         input logic s);
    quiet();
    oper_req  = 1'b1;
    oper_wr   = w;
    fetch_req = also_fetch;
    pre_idle(j, s);
    tick();
    chk("o_bus", {rd, wr, addr}, {~w, w, exp_ir});
    chk("o_busy", busy, 1);
    chk("o_pc", pc, exp_pc);
    chk("o_irv0", {ir_valid, done}, 0);
    for (int k = 0; k < waits; k++) begin
      noise();
      mem_valid = 1'b0;
      tick();
      chk("o_hold", {rd, wr, addr}, {~w, w, exp_ir});
      chk("o_done0", done, 0);
    end
    noise();
    mem_valid = 1'b1;
    tick();
    quiet();
    chk("o_done", done, 1);
    chk("o_idle", {busy, rd, wr, addr}, {3'b000, exp_pc});
  endtask

  task automatic do_ctrl(input logic j, input logic s);
    quiet();
    pre_idle(j, s);
    tick();
    jump = 1'b0;
    skip = 1'b0;
    chk("c_pc", pc, exp_pc);
    chk("c_bus", {busy, rd, wr, addr}, {3'b000, exp_pc});
    chk("c_pulse", {ir_valid, done}, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    fetch_req = 1'b0;
    oper_req  = 1'b0;
    oper_wr   = 1'b0;
    jump      = 1'b0;
    skip      = 1'b0;
    data_in   = 8'h00;
    mem_valid = 1'b0;
    exp_pc    = PC_RST;
    exp_ir    = '0;
    exp_opc   = '0;
    tick();
    tick();
    chk("rst_bus", {busy, rd, wr, addr}, {3'b000, PC_RST});
    chk("rst_pulse", {ir_valid, done}, 0);
    chk("rst_ir", {opcode, ir_addr}, 0);
    chk("rst_pc", pc, PC_RST);
    rst_n = 1'b1;
    tick();

    do_fetch(0, 8'hA5, 8'h3C, 1'b0, 1'b0);
    chk("t1_ir", {opcode, ir_addr}, {3'b101, 13'h053C});
    chk("t1_pc", pc, 13'h0002);
    do_fetch(2, 8'h12, 8'h34, 1'b0, 1'b0);
    chk("t2_ir", ir_addr, 13'h1234);
    do_oper(1'b1, 0, 1'b1, 1'b0, 1'b0);
    do_oper(1'b0, 1, 1'b0, 1'b0, 1'b0);

    do_fetch(0, 8'h0F, 8'hFF, 1'b0, 1'b0);
    do_ctrl(1'b1, 1'b0);
    chk("t4_pc", pc, 13'h0FFF);
    do_fetch(0, 8'hE0, 8'h11, 1'b0, 1'b0);
    chk("t4_wrap", pc, 13'h0001);
    do_fetch(1, 8'h0F, 8'hFE, 1'b0, 1'b0);
    do_ctrl(1'b1, 1'b0);
    do_ctrl(1'b0, 1'b1);
    chk("t4_skip", pc, 13'h0000);
    do_fetch(0, 8'h1A, 8'hBC, 1'b0, 1'b0);
    do_ctrl(1'b1, 1'b1);
    chk("t4_jmp", pc, 13'h0ABC);

    for (int i = 0; i < 300; i++) begin
      int op;
      op = int'($urandom_range(0, 3));
      if (op < 2) begin
        do_fetch(int'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
      end else if (op == 2) begin
        do_oper(1'($urandom), int'($urandom_range(0, 3)),
                1'($urandom),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0));
      end else begin
        do_ctrl(1'($urandom), 1'($urandom));
      end
    end

    quiet();
    mem_valid = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    mem_valid = 1'b1;
    data_in   = 8'h77;
    tick();
    chk("r_pre_rd", rd, 1);
    rst_n = 1'b0;
    #1;
    chk("r_async", {busy, rd, wr, addr}, {3'b000, PC_RST});
    #1;
    rst_n     = 1'b1;
    mem_valid = 1'b0;
    exp_pc    = PC_RST;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r_nopulse", {ir_valid, done}, 0);
      chk("r_pc", {busy, pc}, {1'b0, PC_RST});
    end
    chk("r_ir", {opcode, ir_addr}, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
